// File: rtl/iddr_deser.sv
// DDR bit-pair deserialiser with manual bitslip and training-pattern alignment.
// Collects (Q1,Q2) pairs into DATA_WIDTH-bit words; MSB is the earliest bit.
module iddr_deser #(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 'h5C,
  parameter int LOCK_COUNT = 4,
  parameter int SLIP_WAIT = 2
) (
  input  logic                  C,
  input  logic                  R_N,
  input  logic                  Q1,
  input  logic                  Q2,
  input  logic                  BITSLIP,
  input  logic                  TRAIN_EN,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID,
  output logic [3:0]            SLIP_OFS,
  output logic                  LOCKED,
  output logic                  ALIGN_FAIL
);

  localparam int DW = DATA_WIDTH;
  localparam int HW = DW / 2;
  localparam int PHW = (HW > 1) ? $clog2(HW) : 1;
  localparam logic [PHW-1:0] PH_LAST = PHW'(HW - 1);
  localparam logic [4:0] FILL = 5'(DW);
  localparam logic [3:0] OFS_LAST = 4'(DW - 1);
  localparam logic [5:0] SC_MAX = 6'(2 * DW);
  localparam logic [3:0] MC_MAX = 4'(LOCK_COUNT);
  localparam logic [3:0] WC_MAX = 4'(SLIP_WAIT);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HUNT, ST_WAIT, ST_CONF, ST_LOCK, ST_FAIL
  } state_t;

  state_t state_q, state_d;

  logic [2*DW-3:0] sr;
  logic [2*DW-1:0] sr_nxt;
  logic [DW-1:0]   win;
  logic [PHW-1:0]  ph;
  logic [4:0]      fc;
  logic            fill;
  logic            strobe;
  logic            slip;
  logic            miss;
  logic            match;
  logic [5:0]      sc_q, sc_d;
  logic [2:0]      wc_q, wc_d;
  logic [3:0]      mc_q, mc_d;
  logic            af_q, af_d;

  // Window taken from the post-shift register so a word ends on this cycle's pair
  assign sr_nxt = {sr, Q1, Q2};
  assign win    = DW'(sr_nxt >> SLIP_OFS);
  assign fill   = (fc == FILL);
  assign strobe = fill && (ph == PH_LAST);
  assign match  = (DOUT == TRAIN_PATTERN);

  assign LOCKED     = (state_q == ST_LOCK);
  assign ALIGN_FAIL = af_q;

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      sr         <= '0;
      ph         <= '0;
      fc         <= '0;
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
      SLIP_OFS   <= '0;
    end else begin
      sr         <= sr_nxt[2*DW-3:0];
      ph         <= (ph == PH_LAST) ? '0 : ph + 1'b1;
      DOUT_VALID <= strobe;
      if (!fill)
        fc <= fc + 5'd1;
      if (strobe)
        DOUT <= win;
      if (slip)
        SLIP_OFS <= (SLIP_OFS == OFS_LAST) ? '0 : SLIP_OFS + 4'd1;
    end
  end

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      state_q <= ST_IDLE;
      sc_q    <= '0;
      wc_q    <= '0;
      mc_q    <= '0;
      af_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      wc_q    <= wc_d;
      mc_q    <= mc_d;
      af_q    <= af_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    wc_d    = wc_q;
    mc_d    = mc_q;
    af_d    = af_q;
    slip    = 1'b0;
    miss    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        slip = BITSLIP;
        if (TRAIN_EN) begin
          state_d = ST_HUNT;
          sc_d    = '0;
          af_d    = 1'b0;
        end
      end
      ST_HUNT: begin
        if (DOUT_VALID) begin
          if (match) begin
            mc_d    = 4'd1;
            state_d = (LOCK_COUNT == 1) ? ST_LOCK : ST_CONF;
          end else begin
            miss = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (DOUT_VALID) begin
          if (({1'b0, wc_q} + 4'd1) >= WC_MAX)
            state_d = ST_HUNT;
          else
            wc_d = wc_q + 3'd1;
        end
      end
      ST_CONF: begin
        if (DOUT_VALID) begin
          if (match) begin
            mc_d = mc_q + 4'd1;
            if ((mc_q + 4'd1) == MC_MAX)
              state_d = ST_LOCK;
          end else begin
            miss = 1'b1;
          end
        end
      end
      ST_LOCK: ;
      ST_FAIL: ;
      default: state_d = ST_IDLE;
    endcase
    // A training miss slips even if TRAIN_EN falls in the same cycle
    if (miss) begin
      slip = 1'b1;
      sc_d = sc_q + 6'd1;
      wc_d = '0;
      if ((sc_q + 6'd1) == SC_MAX) begin
        state_d = ST_FAIL;
        af_d    = 1'b1;
      end else begin
        state_d = (SLIP_WAIT == 0) ? ST_HUNT : ST_WAIT;
      end
    end
    if (!TRAIN_EN)
      state_d = ST_IDLE;
  end

endmodule

// File: tb/tb_iddr_deser.sv
// Directed bench for iddr_deser: serial bit-history model feeds a word scoreboard.
module tb_iddr_deser;

  logic       C = 1'b0;
  logic       R_N, Q1, Q2, BITSLIP, TRAIN_EN;
  logic [7:0] DOUT;
  logic       DOUT_VALID;
  logic [3:0] SLIP_OFS;
  logic       LOCKED, ALIGN_FAIL;

  iddr_deser dut (
    .C(C), .R_N(R_N), .Q1(Q1), .Q2(Q2),
    .BITSLIP(BITSLIP), .TRAIN_EN(TRAIN_EN),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
    .SLIP_OFS(SLIP_OFS), .LOCKED(LOCKED),
    .ALIGN_FAIL(ALIGN_FAIL)
  );

  always #5 C = ~C;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int m_ofs = 0;
  int bpos = 7;
  int align_k = -1;
  int slips = 0;
  bit track = 1'b1;
  bit cnt_slips = 1'b0;
  logic [7:0] pat = 8'hA5;
  logic [3:0] prev_ofs = 4'd0;
  bit hist[$];
  logic [7:0] sbq[$];

  function automatic logic [7:0] win(int o);
    logic [7:0] w;
    int idx;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      idx = hist.size() - 1 - o - i;
      w[i] = (idx >= 0) ? hist[idx] : 1'b0;
    end
    return w;
  endfunction

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    bit exp_v;
    logic [7:0] e;
    Q1 = pat[bpos];
    bpos = (bpos + 7) % 8;
    Q2 = pat[bpos];
    bpos = (bpos + 7) % 8;
    @(posedge C);
    cyc++;
    hist.push_back(Q1);
    hist.push_back(Q2);
    while (hist.size() > 40) void'(hist.pop_front());
    exp_v = (cyc % 4 == 0) && (cyc >= 12);
    if (exp_v) begin
      for (int o = 0; o < 8; o++)
        if (win(o) == 8'h5C) align_k = o;
      if (track) sbq.push_back(win(m_ofs % 8));
    end
    #1;
    checks++;
    assert (DOUT_VALID === exp_v) else begin
      errs++;
      $error("FAIL valid cyc=%0d got=%b exp=%b", cyc, DOUT_VALID, exp_v);
    end
    if (DOUT_VALID === 1'b1 && track) begin
      if (sbq.size() == 0) begin
        checks++;
        errs++;
        $error("FAIL sb_empty cyc=%0d got=%0h exp=none", cyc, DOUT);
      end else begin
        e = sbq.pop_front();
        checks++;
        assert (DOUT === e) else begin
          errs++;
          $error("FAIL dout cyc=%0d got=%0h exp=%0h", cyc, DOUT, e);
        end
      end
    end
    if (cnt_slips && SLIP_OFS !== prev_ofs) slips++;
    prev_ofs = SLIP_OFS;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    R_N = 1'b0; Q1 = 1'b0; Q2 = 1'b0;
    BITSLIP = 1'b0; TRAIN_EN = 1'b0;
    #12;
    chk("rst_dout", DOUT, 8'h00);
    chk("rst_valid", {7'd0, DOUT_VALID}, 8'd0);
    chk("rst_ofs", {4'd0, SLIP_OFS}, 8'd0);
    chk("rst_locked", {7'd0, LOCKED}, 8'd0);
    chk("rst_fail", {7'd0, ALIGN_FAIL}, 8'd0);
    @(negedge C);
    R_N = 1'b1;

    // plain 0xA5 stream, offset 0
    repeat (12) step();
    chk("t1_valid", {7'd0, DOUT_VALID}, 8'd1);
    chk("t1_word", DOUT, 8'hA5);
    repeat (8) step();

    // three manual slips in IDLE
    BITSLIP = 1'b1;
    repeat (3) begin
      step();
      m_ofs++;
    end
    BITSLIP = 1'b0;
    chk("t2_ofs", {4'd0, SLIP_OFS}, 8'd3);
    step();
    chk("t2_valid", {7'd0, DOUT_VALID}, 8'd1);
    chk("t2_word", DOUT, 8'hB4);

    // training pattern shifted by 5 bits
    pat = 8'h5C;
    bpos = 2;
    repeat (16) step();
    TRAIN_EN = 1'b1;
    track = 1'b0;
    sbq.delete();
    for (int i = 0; i < 400 && LOCKED !== 1'b1; i++) step();
    chk("t3_locked", {7'd0, LOCKED}, 8'd1);
    chk("t3_ofs", {4'd0, SLIP_OFS}, 8'(align_k));
    chk("t3_word", DOUT, 8'h5C);
    chk("t3_fail", {7'd0, ALIGN_FAIL}, 8'd0);
    m_ofs = align_k;
    track = 1'b1;

    // corrupted bits while locked, then drop training
    repeat (2) step();
    pat = 8'hA3;
    repeat (4) step();
    pat = 8'h5C;
    repeat (12) step();
    chk("t5_locked", {7'd0, LOCKED}, 8'd1);
    TRAIN_EN = 1'b0;
    step();
    chk("t5_unlock", {7'd0, LOCKED}, 8'd0);
    chk("t5_ofs", {4'd0, SLIP_OFS}, 8'(align_k));
    repeat (4) step();
    chk("t5_ofs_hold", {4'd0, SLIP_OFS}, 8'(align_k));

    // all-zero stream never aligns
    pat = 8'h00;
    repeat (16) step();
    slips = 0;
    prev_ofs = SLIP_OFS;
    cnt_slips = 1'b1;
    TRAIN_EN = 1'b1;
    track = 1'b0;
    sbq.delete();
    for (int i = 0; i < 400 && ALIGN_FAIL !== 1'b1; i++) step();
    chk("t4_fail", {7'd0, ALIGN_FAIL}, 8'd1);
    chk("t4_locked", {7'd0, LOCKED}, 8'd0);
    chk("t4_slips", 8'(slips), 8'd16);
    chk("t4_ofs", {4'd0, SLIP_OFS}, 8'(align_k));
    repeat (40) step();
    chk("t4_slips_hold", 8'(slips), 8'd16);
    chk("t4_fail_hold", {7'd0, ALIGN_FAIL}, 8'd1);
    cnt_slips = 1'b0;

    // sticky fail in IDLE, cleared on new hunt, then reset mid-hunt
    TRAIN_EN = 1'b0;
    step();
    chk("t6_sticky", {7'd0, ALIGN_FAIL}, 8'd1);
    pat = 8'hA5;
    bpos = 7;
    repeat (8) step();
    TRAIN_EN = 1'b1;
    step();
    chk("t6_clear", {7'd0, ALIGN_FAIL}, 8'd0);
    repeat (8) step();
    while (cyc % 4 != 2) step();
    #2;
    R_N = 1'b0;
    #1;
    chk("t6_dout", DOUT, 8'h00);
    chk("t6_valid", {7'd0, DOUT_VALID}, 8'd0);
    chk("t6_ofs", {4'd0, SLIP_OFS}, 8'd0);
    chk("t6_locked", {7'd0, LOCKED}, 8'd0);
    chk("t6_fail", {7'd0, ALIGN_FAIL}, 8'd0);
    @(negedge C);
    TRAIN_EN = 1'b0;
    track = 1'b1;
    sbq.delete();
    hist.delete();
    m_ofs = 0;
    pat = 8'hA5;
    bpos = 7;
    cyc = 0;
    R_N = 1'b1;
    repeat (16) step();
    chk("t6_word", DOUT, 8'hA5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
